// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
//   ADDRESS_WIDTH_DEF / DATA_WIDTH_DEF : default register index / result widths
//   ZERO_REG                           : architectural zero register index (never written)
//   wb_src_e                           : which source drives the write port this cycle
package writeback_arbiter_pkg;

  localparam int ADDRESS_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF    = 32;

  localparam logic [ADDRESS_WIDTH_DEF-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LSU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of all writeback-stage signals between the pipeline and the arbiter.
//   ALU side   : alu_valid, alu_rd, alu_data in; alu_hold out
//   LSU side   : lsu_valid, lsu_rd, lsu_data in; lsu_ready out
//   Issue side : issue_valid, issue_rd in
//   Decode     : check_addr_1/2 in; busy_1/2 out (combinational)
//   Regfile    : RegWrite, WRITE_ADDRESS, WRITE_DATA out (registered)
// master = pipeline/regfile side, slave = arbiter.
interface writeback_arbiter_if
  import writeback_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
);

  logic                     alu_valid;
  logic [ADDRESS_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     alu_hold;

  logic                     lsu_valid;
  logic                     lsu_ready;
  logic [ADDRESS_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0]    lsu_data;

  logic                     issue_valid;
  logic [ADDRESS_WIDTH-1:0] issue_rd;

  logic [ADDRESS_WIDTH-1:0] check_addr_1;
  logic [ADDRESS_WIDTH-1:0] check_addr_2;
  logic                     busy_1;
  logic                     busy_2;

  logic                     RegWrite;
  logic [ADDRESS_WIDTH-1:0] WRITE_ADDRESS;
  logic [DATA_WIDTH-1:0]    WRITE_DATA;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, check_addr_1, check_addr_2,
    input  alu_hold, lsu_ready, busy_1, busy_2, RegWrite, WRITE_ADDRESS, WRITE_DATA
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           issue_valid, issue_rd, check_addr_1, check_addr_2,
    output alu_hold, lsu_ready, busy_1, busy_2, RegWrite, WRITE_ADDRESS, WRITE_DATA
  );

endinterface

// File: rtl/writeback_arbiter_wb_result_fifo.sv
// Circular skid buffer for long-latency results.
//   clock, reset     : clock, asynchronous active-high reset
//   i_push / i_wdata : enqueue request and entry (ignored when full)
//   i_pop            : dequeue head (ignored when empty)
//   o_rdata          : current head entry
//   o_full / o_empty : occupancy flags from the registered count
module wb_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter feeding the register file write port.
//   clock, reset : clock, asynchronous active-high reset
//   bus (slave)  : ALU/LSU result inputs, issue tracking, decode busy lookups
//                  and the registered RegWrite / WRITE_ADDRESS / WRITE_DATA port.
// ALU results win the port unless alu_hold is up; long-latency results queue
// in a small FIFO, and a starvation counter forces a one-cycle alu_hold so the
// FIFO head is eventually drained. A pending bit per register tracks
// in-flight long-latency destinations for decode hazard checks.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                clock,
  input  logic                reset,
  writeback_arbiter_if.slave  bus
);

  localparam int ENTRY_W  = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int NUM_REGS = 1 << ADDRESS_WIDTH;
  localparam int SCNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_RD = ADDRESS_WIDTH'(ZERO_REG);

  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [ENTRY_W-1:0]       w_head;
  logic [ADDRESS_WIDTH-1:0] w_head_rd;
  logic [DATA_WIDTH-1:0]    w_head_data;
  logic                     w_alu_win;
  logic                     w_pop;
  logic                     w_push;
  wb_src_e                  w_src;
  logic [NUM_REGS-1:0]      w_pending_next;

  logic                     r_reg_write;
  logic [ADDRESS_WIDTH-1:0] r_write_addr;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic                     r_alu_hold;
  logic [SCNT_W-1:0]        r_starve;
  logic [NUM_REGS-1:0]      r_pending;

  // Ready is gated by reset so nothing is accepted while it is asserted;
  // it depends only on the current count, never on a same-cycle pop.
  assign bus.lsu_ready = !reset && !w_fifo_full;
  // Results for the zero register are accepted but never stored.
  assign w_push    = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != ZERO_RD);
  assign w_alu_win = !r_alu_hold && bus.alu_valid && (bus.alu_rd != ZERO_RD);

  assign w_head_rd   = w_head[ENTRY_W-1:DATA_WIDTH];
  assign w_head_data = w_head[DATA_WIDTH-1:0];

  always_comb begin
    w_src = WB_SRC_NONE;
    if (w_alu_win)          w_src = WB_SRC_ALU;
    else if (!w_fifo_empty) w_src = WB_SRC_LSU;
  end

  assign w_pop = (w_src == WB_SRC_LSU);

  wb_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({bus.lsu_rd, bus.lsu_data}),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Write port stage: registers load one edge after selection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      case (w_src)
        WB_SRC_ALU: begin
          r_reg_write  <= 1'b1;
          r_write_addr <= bus.alu_rd;
          r_write_data <= bus.alu_data;
        end
        WB_SRC_LSU: begin
          r_reg_write  <= 1'b1;
          r_write_addr <= w_head_rd;
          r_write_data <= w_head_data;
        end
        default: r_reg_write <= 1'b0;
      endcase
    end
  end

  // Hold is raised on the edge where the stall count would reach the limit,
  // so it is visible for exactly one cycle; that cycle always pops, which
  // also clears the counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alu_hold <= 1'b0;
      r_starve   <= '0;
    end else begin
      r_alu_hold <= 1'b0;
      if (!w_fifo_empty && !w_pop) begin
        if (r_starve == SCNT_W'(STARVE_LIMIT - 1)) begin
          r_alu_hold <= 1'b1;
          r_starve   <= '0;
        end else begin
          r_starve <= r_starve + 1'b1;
        end
      end else begin
        r_starve <= '0;
      end
    end
  end

  // Clear on pop first so a same-cycle issue to the same register wins.
  always_comb begin
    w_pending_next = r_pending;
    if (w_pop) w_pending_next[w_head_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != ZERO_RD)) w_pending_next[bus.issue_rd] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_pending_next;
  end

  assign bus.busy_1        = r_pending[bus.check_addr_1];
  assign bus.busy_2        = r_pending[bus.check_addr_2];
  assign bus.alu_hold      = r_alu_hold;
  assign bus.RegWrite      = r_reg_write;
  assign bus.WRITE_ADDRESS = r_write_addr;
  assign bus.WRITE_DATA    = r_write_data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios plus random traffic,
// with expected register-file writes queued by a reference model and
// compared by an independent monitor.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  writeback_arbiter_if bus ();

  writeback_arbiter #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  wr_t         exp_q[$];
  ent_t        m_fifo[$];
  bit [31:0]   m_pend;
  int          m_starve;
  bit          m_hold;
  logic [4:0]  m_last_addr;
  logic [31:0] m_last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fifo.delete();
    m_pend      = '0;
    m_starve    = 0;
    m_hold      = 1'b0;
    m_last_addr = '0;
    m_last_data = '0;
  endtask

  // One cycle: apply inputs at the falling edge, check combinational outputs,
  // advance the model and queue the write expected at the next rising edge.
  task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lr, input logic [31:0] ld,
                       input bit iv, input logic [4:0] ir,
                       input logic [4:0] c1, input logic [4:0] c2,
                       output bit xfer);
    wr_t  w;
    ent_t e;
    bit   ready, nonempty, popped;
    @(negedge clock);
    bus.alu_valid = av;  bus.alu_rd = ar;  bus.alu_data = ad;
    bus.lsu_valid = lv;  bus.lsu_rd = lr;  bus.lsu_data = ld;
    bus.issue_valid = iv; bus.issue_rd = ir;
    bus.check_addr_1 = c1; bus.check_addr_2 = c2;
    #1;
    ready = (m_fifo.size() < FIFO_DEPTH);
    check("lsu_ready", 32'(bus.lsu_ready), 32'(ready));
    check("alu_hold",  32'(bus.alu_hold),  32'(m_hold));
    check("busy_1",    32'(bus.busy_1),    32'(m_pend[c1]));
    check("busy_2",    32'(bus.busy_2),    32'(m_pend[c2]));
    if (av && m_hold) begin
      checks++;
      errors++;
      $display("FAIL protocol: alu_valid during alu_hold at %0t", $time);
    end
    xfer     = lv && ready;
    nonempty = (m_fifo.size() > 0);
    popped   = 1'b0;
    if (av && !m_hold && ar != 5'd0) begin
      m_last_addr = ar; m_last_data = ad;
      w.we = 1'b1;
    end else if (nonempty) begin
      e = m_fifo.pop_front();
      m_pend[e.rd] = 1'b0;
      m_last_addr = e.rd; m_last_data = e.data;
      popped = 1'b1;
      w.we = 1'b1;
    end else begin
      w.we = 1'b0;
    end
    w.addr = m_last_addr;
    w.data = m_last_data;
    exp_q.push_back(w);
    if (xfer && lr != 5'd0) begin
      e.rd = lr; e.data = ld;
      m_fifo.push_back(e);
    end
    if (iv && ir != 5'd0) m_pend[ir] = 1'b1;
    m_pend[0] = 1'b0;
    m_hold = 1'b0;
    if (nonempty && !popped) begin
      m_starve++;
      if (m_starve == STARVE_LIMIT) begin
        m_hold   = 1'b1;
        m_starve = 0;
      end
    end else begin
      m_starve = 0;
    end
  endtask

  task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
    bit x;
    drive(0, 0, 0, 0, 0, 0, 0, 0, c1, c2, x);
  endtask

  // Monitor: compares the write port just after every rising edge.
  initial begin
    wr_t w;
    forever begin
      @(posedge clock);
      #1;
      if (reset) continue;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(bus.RegWrite), 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("RegWrite",      32'(bus.RegWrite),      32'(w.we));
        check("WRITE_ADDRESS", 32'(bus.WRITE_ADDRESS), 32'(w.addr));
        check("WRITE_DATA",    bus.WRITE_DATA,         w.data);
      end
    end
  end

  initial begin
    bit x;
    int k;
    int holds;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0;
    bus.check_addr_1 = 0; bus.check_addr_2 = 0;
    model_reset();
    #2;
    check("reset_RegWrite", 32'(bus.RegWrite), 32'd0);
    check("reset_ADDR",     32'(bus.WRITE_ADDRESS), 32'd0);
    check("reset_DATA",     bus.WRITE_DATA, 32'd0);
    check("reset_hold",     32'(bus.alu_hold), 32'd0);
    check("reset_ready",    32'(bus.lsu_ready), 32'd0);
    #10 reset = 1'b0;

    // ALU write, then ALU to the zero register
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, x);
    drive(1, 0, 32'h11111111, 0, 0, 0, 0, 0, 0, 0, x);
    idle(0, 0);

    // Issue rd 7, long-latency return of 0x12 with the ALU idle
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, x);
    idle(7, 0);
    drive(0, 0, 0, 1, 7, 32'h12, 0, 0, 7, 7, x);
    idle(7, 0);
    idle(7, 7);
    check("busy7_cleared", 32'(bus.busy_1), 32'd0);

    // Two results back-to-back against a continuously valid ALU
    holds = 0;
    for (int i = 0; i < 8; i++) begin
      drive(!m_hold, 9, 32'h900 + 32'(i), (i < 2), 5'(12 + i), 32'hA0 + 32'(i), 0, 0, 12, 13, x);
      if (bus.alu_hold) holds++;
    end
    check("hold_cycles", 32'(holds), 32'd1);
    repeat (4) idle(0, 0);

    // Fill the FIFO, then keep pushing while it drains: rd 1..6 in order
    k = 1;
    for (int i = 0; i < 20 && k <= 6; i++) begin
      drive((i < 2) && !m_hold, 20, 32'hC0 + 32'(i), 1, 5'(k), 32'h100 + 32'(k), 0, 0, 5'(k), 1, x);
      if (x) k++;
    end
    check("six_accepted", 32'(k), 32'd7);
    repeat (4) idle(1, 6);

    // Same-cycle issue and pop on rd 3: set wins; issue to rd 0 never marks busy
    drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0, x);
    drive(1, 8, 32'h88, 1, 3, 32'h33, 0, 0, 3, 0, x);
    drive(0, 0, 0, 0, 0, 0, 1, 3, 3, 0, x);
    idle(3, 0);
    check("pend3_set_wins", 32'(bus.busy_1), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, x);
    idle(0, 3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) && !m_hold, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), x);
    end

    // Asynchronous reset with two queued results and pending bits set
    drive(0, 0, 0, 0, 0, 0, 1, 10, 10, 11, x);
    drive(0, 0, 0, 0, 0, 0, 1, 11, 10, 11, x);
    drive(!m_hold, 21, 32'h2121, 1, 10, 32'hAA, 0, 0, 10, 11, x);
    drive(!m_hold, 22, 32'h2222, 1, 11, 32'hBB, 0, 0, 10, 11, x);
    drive(!m_hold, 23, 32'h2323, 0, 0, 0, 0, 0, 10, 11, x);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_RegWrite", 32'(bus.RegWrite), 32'd0);
    check("async_busy_1",   32'(bus.busy_1),   32'd0);
    check("async_busy_2",   32'(bus.busy_2),   32'd0);
    check("async_ready",    32'(bus.lsu_ready), 32'd0);
    bus.alu_valid = 0; bus.lsu_valid = 0; bus.issue_valid = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (6) idle(10, 11);

    @(posedge clock);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback stage directly upstream of the 32x32 register file write port (RegWrite / WRITE_ADDRESS / WRITE_DATA).
- Merges single-cycle ALU results with long-latency load/multiply results, using a small skid FIFO.
- Keeps a pending-destination scoreboard so decode can stall on RAW hazards against in-flight long-latency ops.
- Guarantees long-latency results cannot be starved forever.

Parameters:
- ADDRESS_WIDTH, 5: register index width.
- DATA_WIDTH, 32: result data width.
- FIFO_DEPTH, 2: long-latency result buffer entries; power of two, at least 2.
- STARVE_LIMIT, 4: consecutive non-empty cycles without a FIFO pop before ALU hold is forced.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; no backpressure except alu_hold.
- alu_rd  in  ADDRESS_WIDTH  ALU destination.
- alu_data  in  DATA_WIDTH  ALU result.
- alu_hold  out  1  registered; ALU must not present a result this cycle.
- lsu_valid  in  1  long-latency result offered.
- lsu_ready  out  1  FIFO can accept.
- lsu_rd  in  ADDRESS_WIDTH  long-latency destination.
- lsu_data  in  DATA_WIDTH  long-latency result.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  ADDRESS_WIDTH  destination of issued op.
- check_addr_1, check_addr_2  in  ADDRESS_WIDTH  decode source operands.
- busy_1, busy_2  out  1  combinational pending status of check_addr_1 / check_addr_2.
- RegWrite  out  1  registered write enable to the register file.
- WRITE_ADDRESS  out  ADDRESS_WIDTH  registered write index.
- WRITE_DATA  out  DATA_WIDTH  registered write data.

Behaviour:
- Reset is asynchronous and active-high.
  - RegWrite=0, WRITE_ADDRESS=0, WRITE_DATA=0, alu_hold=0.
  - FIFO empty; all pending bits 0; starve counter 0.
  - lsu_ready=0 while reset is asserted.
  - Reset mid-operation discards all buffered results and pending state.
- LSU handshake:
  - Transfer occurs when lsu_valid && lsu_ready.
  - lsu_ready = !full, computed from the current count only; a pop in the same cycle does not raise ready.
  - Transferred result with lsu_rd==0 is consumed and dropped, not enqueued.
- Write selection each cycle; the write-port registers load on the next edge (latency 1):
  - Priority 1: alu_hold==0 && alu_valid && alu_rd!=0 -> write ALU result.
  - Priority 2: else FIFO non-empty -> pop head and write it.
  - Otherwise RegWrite=0; WRITE_ADDRESS and WRITE_DATA hold their previous values.
  - ALU result with alu_rd==0 performs no write, and the FIFO may pop that cycle.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and not popped; it clears on a pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, alu_hold=1 for exactly one cycle and the counter clears.
  - alu_valid during alu_hold is a protocol violation. The FIFO still pops and the ALU result is dropped; the bench flags it.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and a count.
  - Simultaneous push and pop is legal when not full; count is unchanged.
- Scoreboard, one pending bit per register:
  - Set on issue_valid && issue_rd!=0.
  - Cleared when a FIFO entry is popped to the write port for that rd.
  - Same-cycle set and clear on the same rd: set wins.
  - Bit 0 is never set.
  - busy_n = pending[check_addr_n]; it reflects register state only, with no bypass of same-cycle issue.
- ALU writes never touch the scoreboard.

Decomposition:
- Shared package holds:
  - ADDRESS_WIDTH and DATA_WIDTH defaults.
  - Zero-register constant.
  - Write-source encoding constants: NONE, ALU, LSU.
- One natural sub-module: wb_result_fifo (parameterised FIFO, DATA_WIDTH+ADDRESS_WIDTH wide, with push/pop/full/empty).
- Arbiter, starve counter and scoreboard stay in the top.

Test Plan:
- ALU only, rd=5, data=0xDEADBEEF -> next edge: RegWrite=1, WRITE_ADDRESS=5, WRITE_DATA=0xDEADBEEF; rd=0 gives RegWrite=0.
- issue rd=7; LSU returns rd=7, data=0x12 with ALU idle -> busy for 7 is 1 until the pop; write of 0x12 one cycle after enqueue; busy 0 the cycle after the pop edge.
- Two LSU results back-to-back while ALU is valid every cycle -> lsu_ready drops to 0 after 2 pushes; after 4 stalled cycles alu_hold=1 for one cycle, head popped; ready returns.
- Fill FIFO, then push+pop with wrap (6 results total, rd 1..6, ALU idle) -> writes emerge in order 1..6, no loss or duplication.
- Same-cycle issue rd=3 and LSU pop for rd=3 -> pending[3] stays 1; issue rd=0 -> busy stays 0.
- Reset asserted asynchronously mid-stream with 2 FIFO entries and pending bits set -> RegWrite=0 immediately, all busy 0, no writes after release until new input.
